// File: rtl/adc_pkg.sv
// Shared constants and FSM state type for the ADC RAM readout path.
// Pure declarations; no timing or flow control of its own.
package adc_pkg;

    localparam int ADDR_W = 13;
    localparam int DATA_W = 32;
    localparam int NBANKS = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } readout_state_t;

endpackage

// File: rtl/readout_fifo.sv
// Synchronous FIFO with flush; head entry visible combinationally, 1-cycle push-to-empty-clear latency.
// Push when full is ignored unless a pop happens in the same cycle; flush beats push and pop.
module readout_fifo #(
    parameter  int WIDTH = 96,
    parameter  int DEPTH = 2,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             flush_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_dat_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] head_dat_o,
    output logic [CNT_W-1:0] count_o,
    output logic             empty_o,
    output logic             full_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             wr_en, rd_en;

    assign empty_o    = (count_q == '0);
    assign full_o     = (count_q == CNT_W'(DEPTH));
    assign count_o    = count_q;
    assign head_dat_o = mem_q[rd_ptr_q];
    assign rd_en      = pop_i && !empty_o;
    assign wr_en      = push_i && (!full_o || rd_en);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (wr_en) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (rd_en) rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({wr_en, rd_en})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage needs no reset: entries are only observed once counted.
    always_ff @(posedge clk_i) begin
        if (wr_en && !flush_i) mem_q[wr_ptr_q] <= push_dat_i;
    end

endmodule

// File: rtl/adc_ram_readout.sv
// Streams RAM addresses 0..recLen of all banks as DATA_W words; first word 2 cycles after trigger edge.
// Reads are issued only when FIFO space covers in-flight data, so iTxReady stalls just pause the RAM reads.
module adc_ram_readout #(
    parameter int ADDR_W     = adc_pkg::ADDR_W,
    parameter int DATA_W     = adc_pkg::DATA_W,
    parameter int NBANKS     = adc_pkg::NBANKS,
    parameter int FIFO_DEPTH = 2
) (
    input  logic                     ocramCLK,
    input  logic                     iResetN,
    input  logic                     iTransmitReady,
    input  logic [ADDR_W-1:0]        iRecLength,
    input  logic                     iAbort,
    output logic [ADDR_W-1:0]        oRAddr,
    output logic                     oRDEN,
    input  logic [NBANKS*DATA_W-1:0] iRData,
    output logic [DATA_W-1:0]        oTxData,
    output logic                     oTxValid,
    input  logic                     iTxReady,
    output logic                     oTxLast,
    output logic                     oBusy,
    output logic                     oReadoutDone
);
    import adc_pkg::*;

    localparam int SEL_W = 2;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int ROW_W = NBANKS * DATA_W;

    readout_state_t    state_q, state_d;
    logic              trig_prev_q;
    logic [ADDR_W-1:0] rec_len_q, rec_len_d;
    logic [ADDR_W-1:0] raddr_q, raddr_d;
    logic [ADDR_W-1:0] out_addr_q, out_addr_d;
    logic [SEL_W-1:0]  sel_q, sel_d;
    logic              rd_pend_q;

    logic              start, issue, flush, pop, tx_fire, last_sel, last_row;
    logic              fifo_empty, fifo_full;
    logic [CNT_W-1:0]  fifo_count;
    logic [CNT_W:0]    occupancy;
    logic [ROW_W-1:0]  head_dat;
    logic [DATA_W-1:0] tx_dat;

    readout_fifo #(
        .WIDTH (ROW_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i      (ocramCLK),
        .rst_ni     (iResetN),
        .flush_i    (flush),
        .push_i     (rd_pend_q),
        .push_dat_i (iRData),
        .pop_i      (pop),
        .head_dat_o (head_dat),
        .count_o    (fifo_count),
        .empty_o    (fifo_empty),
        .full_o     (fifo_full)
    );

    assign start     = iTransmitReady && !trig_prev_q;
    assign occupancy = {1'b0, fifo_count} + {{CNT_W{1'b0}}, rd_pend_q};
    assign last_sel  = (sel_q == SEL_W'(NBANKS - 1));
    assign last_row  = (out_addr_q == rec_len_q);
    assign tx_fire   = !fifo_empty && iTxReady;
    assign pop       = tx_fire && last_sel;

    always_comb begin
        tx_dat = head_dat[DATA_W-1:0];
        for (int k = 1; k < NBANKS; k++) begin
            if (sel_q == SEL_W'(k)) tx_dat = head_dat[k*DATA_W +: DATA_W];
        end
    end

    always_comb begin
        state_d    = state_q;
        rec_len_d  = rec_len_q;
        raddr_d    = raddr_q;
        out_addr_d = out_addr_q;
        sel_d      = sel_q;
        issue      = 1'b0;
        flush      = 1'b0;

        if (tx_fire) begin
            if (last_sel) begin
                sel_d      = '0;
                out_addr_d = out_addr_q + 1'b1;
            end else begin
                sel_d = sel_q + 1'b1;
            end
        end

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d    = READ;
                    rec_len_d  = iRecLength;
                    raddr_d    = '0;
                    out_addr_d = '0;
                    sel_d      = '0;
                    flush      = 1'b1;
                end
            end
            READ: begin
                issue = !fifo_full && (occupancy < (CNT_W + 1)'(FIFO_DEPTH));
                // Hold raddr at recLen after the final issue so the top address never wraps.
                if (issue) begin
                    if (raddr_q == rec_len_q) state_d = DRAIN;
                    else                      raddr_d = raddr_q + 1'b1;
                end
            end
            DRAIN: begin
                if (!rd_pend_q && (fifo_empty || (pop && fifo_count == CNT_W'(1))))
                    state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (iAbort) begin
            state_d = IDLE;
            sel_d   = '0;
            issue   = 1'b0;
            flush   = 1'b1;
        end
    end

    always_ff @(posedge ocramCLK or negedge iResetN) begin
        if (!iResetN) begin
            state_q     <= IDLE;
            // Treat the trigger as already high so a level present at reset release is not an edge.
            trig_prev_q <= 1'b1;
            rec_len_q   <= '0;
            raddr_q     <= '0;
            out_addr_q  <= '0;
            sel_q       <= '0;
            rd_pend_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            trig_prev_q <= iTransmitReady;
            rec_len_q   <= rec_len_d;
            raddr_q     <= raddr_d;
            out_addr_q  <= out_addr_d;
            sel_q       <= sel_d;
            rd_pend_q   <= issue;
        end
    end

    assign oRAddr       = raddr_q;
    assign oRDEN        = issue;
    assign oTxValid     = !fifo_empty;
    assign oTxData      = fifo_empty ? '0 : tx_dat;
    assign oTxLast      = !fifo_empty && last_sel && last_row;
    assign oBusy        = (state_q != IDLE);
    assign oReadoutDone = (state_q == DONE);

endmodule

// File: tb/tb_adc_ram_readout.sv
// Scoreboard bench for adc_ram_readout: a behavioural RAM answers reads with {run,bank,addr} tags.
module tb_adc_ram_readout;
    import adc_pkg::*;

    localparam int AW = ADDR_W;
    localparam int DW = DATA_W;
    localparam int NB = NBANKS;

    typedef struct packed {
        logic [DW-1:0] dat;
        logic          last;
        logic          row_end;
    } exp_t;

    logic             ocramCLK = 1'b0;
    logic             iResetN, iTransmitReady, iAbort, iTxReady;
    logic [AW-1:0]    iRecLength;
    logic [NB*DW-1:0] iRData;
    logic [AW-1:0]    oRAddr;
    logic             oRDEN, oTxValid, oTxLast, oBusy, oReadoutDone;
    logic [DW-1:0]    oTxData;

    int   n_vec = 0, n_err = 0;
    exp_t sb[$];
    int   run_id = 0, cyc = 0, done_cnt = 0, last_hs_cyc = 0, done_gap = -1;
    int   rd_cnt = 0, addr_err = 0, max_addr = 0, stab_err = 0;
    int   rows_issued = 0, rows_popped = 0, max_outst = 0, words = 0, rdy_mode = 0;
    logic stall_q = 1'b0, abort_prev = 1'b0, stall_last = 1'b0;
    logic [DW-1:0] stall_dat = '0;

    always #5 ocramCLK = ~ocramCLK;

    adc_ram_readout dut (
        .ocramCLK       (ocramCLK),
        .iResetN        (iResetN),
        .iTransmitReady (iTransmitReady),
        .iRecLength     (iRecLength),
        .iAbort         (iAbort),
        .oRAddr         (oRAddr),
        .oRDEN          (oRDEN),
        .iRData         (iRData),
        .oTxData        (oTxData),
        .oTxValid       (oTxValid),
        .iTxReady       (iTxReady),
        .oTxLast        (oTxLast),
        .oBusy          (oBusy),
        .oReadoutDone   (oReadoutDone)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] tag(input int run, input int addr, input int bank);
        return {8'(run), 8'(bank), 16'(addr)};
    endfunction

    // RAM model: data one cycle after the read enable, junk otherwise.
    always @(posedge ocramCLK) begin
        if (oRDEN) begin
            for (int k = 0; k < NB; k++) iRData[k*DW +: DW] <= tag(run_id, int'(oRAddr), k);
        end else begin
            iRData <= {$urandom, $urandom, $urandom};
        end
    end

    initial begin
        iTxReady = 1'b1;
        forever begin
            @(posedge ocramCLK);
            #1;
            iTxReady = (rdy_mode == 0) ? 1'b1 : ($urandom_range(0, 99) < 30);
        end
    end

    // Monitor: sampled mid-cycle, each valid&&ready here handshakes on the next rising edge.
    always @(negedge ocramCLK) begin
        exp_t e;
        cyc++;
        if (!iResetN) begin
            stall_q = 1'b0;
        end else begin
            if (oRDEN) begin
                if (int'(oRAddr) != rd_cnt) addr_err++;
                if (int'(oRAddr) > max_addr) max_addr = int'(oRAddr);
                rd_cnt++;
                rows_issued++;
                if (rows_issued - rows_popped > max_outst) max_outst = rows_issued - rows_popped;
            end
            if (stall_q && !abort_prev &&
                (!oTxValid || oTxData !== stall_dat || oTxLast !== stall_last)) stab_err++;
            if (oTxValid && iTxReady) begin
                if (sb.size() == 0) begin
                    check("extra_word", 32'(oTxData), 32'hFFFF_FFFF);
                end else begin
                    e = sb.pop_front();
                    check("tx_data", 32'(oTxData), 32'(e.dat));
                    check("tx_last", 32'(oTxLast), 32'(e.last));
                    words++;
                    if (e.row_end) rows_popped++;
                    if (e.last) last_hs_cyc = cyc;
                end
            end
            if (oReadoutDone) begin
                done_cnt++;
                done_gap = cyc - last_hs_cyc;
            end
            stall_q = oTxValid && !iTxReady;
        end
        stall_dat  = oTxData;
        stall_last = oTxLast;
        abort_prev = iAbort;
    end

    task automatic start_run(input int len);
        run_id++;
        rd_cnt = 0; addr_err = 0; max_addr = 0; stab_err = 0;
        rows_issued = 0; rows_popped = 0; max_outst = 0; words = 0; done_gap = -1;
        for (int a = 0; a <= len; a++)
            for (int b = 0; b < NB; b++)
                sb.push_back('{dat: tag(run_id, a, b), last: (a == len && b == NB - 1),
                               row_end: (b == NB - 1)});
        iRecLength = AW'(len);
        iTransmitReady = 1'b1;
        @(posedge ocramCLK); #1;
        iTransmitReady = 1'b0;
        iRecLength = '0;
        check("lat_c0", 32'(oTxValid), 32'd0);
        @(posedge ocramCLK); #1;
        check("lat_c1", 32'(oTxValid), 32'd0);
        @(posedge ocramCLK); #1;
        check("lat_c2", 32'(oTxValid), 32'd1);
    endtask

    task automatic finish_run(input int len, input int d0);
        int t = 0;
        int bound = 3 * (len + 1) * ((rdy_mode != 0) ? 8 : 2) + 100;
        while (done_cnt == d0 && t < bound) begin
            @(posedge ocramCLK); #1;
            t++;
        end
        check("done_seen", 32'(done_cnt - d0), 32'd1);
        repeat (5) @(posedge ocramCLK);
        #1;
        check("done_once", 32'(done_cnt - d0), 32'd1);
        check("done_gap", 32'(done_gap), 32'd1);
        check("sb_empty", 32'(sb.size()), 32'd0);
        check("words", 32'(words), 32'(3 * (len + 1)));
        check("rden_cnt", 32'(rd_cnt), 32'(len + 1));
        check("raddr_seq", 32'(addr_err), 32'd0);
        check("raddr_peak", 32'(max_addr), 32'(len));
        check("fifo_occ_le2", 32'(max_outst <= 2), 32'd1);
        check("stall_stable", 32'(stab_err), 32'd0);
        check("busy_idle", 32'(oBusy), 32'd0);
    endtask

    initial begin
        int d0, t;
        iResetN = 1'b0; iTransmitReady = 1'b0; iAbort = 1'b0; iRecLength = '0;
        repeat (3) @(posedge ocramCLK);
        #1;
        check("rst_valid", 32'(oTxValid), 32'd0);
        check("rst_rden", 32'(oRDEN), 32'd0);
        check("rst_busy", 32'(oBusy), 32'd0);
        check("rst_done", 32'(oReadoutDone), 32'd0);
        check("rst_last", 32'(oTxLast), 32'd0);
        check("rst_addr", 32'(oRAddr), 32'd0);
        check("rst_data", 32'(oTxData), 32'd0);
        iResetN = 1'b1;
        repeat (2) @(posedge ocramCLK);
        #1;

        d0 = done_cnt; start_run(3);    finish_run(3, d0);
        d0 = done_cnt; start_run(0);    finish_run(0, d0);
        rdy_mode = 1;
        d0 = done_cnt; start_run(15);   finish_run(15, d0);
        rdy_mode = 0;
        d0 = done_cnt; start_run(8191); finish_run(8191, d0);

        // Abort after the 7th accepted word.
        d0 = done_cnt; start_run(10);
        t = 0;
        while (words < 7 && t < 200) begin
            @(posedge ocramCLK); #1;
            t++;
        end
        check("abort_reach", 32'(words >= 7), 32'd1);
        iAbort = 1'b1;
        @(posedge ocramCLK); #1;
        iAbort = 1'b0;
        check("abort_valid", 32'(oTxValid), 32'd0);
        check("abort_rden", 32'(oRDEN), 32'd0);
        check("abort_busy", 32'(oBusy), 32'd0);
        sb.delete();
        repeat (30) @(posedge ocramCLK);
        #1;
        check("abort_nodone", 32'(done_cnt - d0), 32'd0);
        check("abort_quiet", 32'(oTxValid), 32'd0);
        d0 = done_cnt; start_run(10);   finish_run(10, d0);

        // Reset mid-READ with the trigger level held high through release.
        rdy_mode = 1;
        start_run(15);
        repeat (4) @(posedge ocramCLK);
        #1;
        iTransmitReady = 1'b1;
        iResetN = 1'b0;
        #1;
        check("mrst_valid", 32'(oTxValid), 32'd0);
        check("mrst_rden", 32'(oRDEN), 32'd0);
        check("mrst_busy", 32'(oBusy), 32'd0);
        check("mrst_last", 32'(oTxLast), 32'd0);
        sb.delete();
        repeat (3) @(posedge ocramCLK);
        #1;
        rd_cnt = 0;
        iResetN = 1'b1;
        repeat (10) @(posedge ocramCLK);
        #1;
        check("no_autostart_busy", 32'(oBusy), 32'd0);
        check("no_autostart_rden", 32'(rd_cnt), 32'd0);
        iTransmitReady = 1'b0;
        rdy_mode = 0;
        @(posedge ocramCLK); #1;
        d0 = done_cnt; start_run(2);    finish_run(2, d0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
